load_store_unit: RTL

Sits between the core's memory-stage and the word-wide data memory, directly upstream of it. Turns RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on the memory's single port. Sub-word stores use a read-modify-write sequence, and loads are sign- or zero-extended. A small FSM with a valid/ready request handshake and a one-cycle response pulse sequences each access.

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Core-side request/response bus of the load/store unit.
//   master : memory stage of the core (drives requests, receives responses)
//   slave  : load_store_unit
// Signals:
//   req_valid/req_ready : request handshake, accepted when both are high
//   is_store, funct3    : access kind and RV32I size/sign encoding
//   addr, wdata         : byte address and store data
//   resp_valid          : one-cycle completion pulse
//   rdata, misaligned   : extended load data and alignment flag, valid with resp_valid
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        misaligned;

  modport master (
    output req_valid, is_store, funct3, addr, wdata,
    input  req_ready, resp_valid, rdata, misaligned
  );

  modport slave (
    input  req_valid, is_store, funct3, addr, wdata,
    output req_ready, resp_valid, rdata, misaligned
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// Converts RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into accesses on a
// single-port word-wide data memory. Sub-word stores are read-modify-write;
// loads are sign/zero extended.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   bus (slave)         : core request/response bus, see load_store_unit_if
//   mem_addr            : word-aligned memory address, 0 while idle
//   mem_should_write    : memory write enable (memory commits on falling edge)
//   mem_write_data      : full word to write
//   mem_read_data       : combinational memory read data
// Parameter LOAD_RESP_REG:
//   1 : rdata is cleared after each response (valid only with resp_valid)
//   0 : rdata holds the last load result until the next load response
// Macro LSU_MISALIGN_TRAP_EN:
//   defined   : misaligned accesses skip the memory and respond with misaligned=1
//   undefined : no detection; halfword lane from addr[1], words ignore addr[1:0]
//
// state | meaning
// IDLE  | ready for a request, memory bus quiet
// LOAD  | memory read, extract and extend the addressed lane
// MERGE | memory read, splice store lane into the word (sub-word store)
// WRITE | write enable high for one cycle
// RESP  | resp_valid pulse, then back to IDLE
module load_store_unit #(
  parameter bit LOAD_RESP_REG = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus,
  output logic [31:0]        mem_addr,
  output logic               mem_should_write,
  output logic [31:0]        mem_write_data,
  input  logic [31:0]        mem_read_data
);

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        is_store_q;
  logic        mis_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;

  logic        req_mis;
  logic        sz_byte;
  logic        sz_half;
  logic [4:0]  shamt;
  logic [31:0] lane_mask;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Alignment is judged on the incoming request so a misaligned access goes
  // straight to RESP without ever touching the memory.
  always_comb begin
    req_mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (bus.funct3[1])
      req_mis = (bus.addr[1:0] != 2'b00);
    else if (bus.funct3[0])
      req_mis = bus.addr[0];
`endif
  end

  // funct3[1:0]: 00 byte, 01 half, 1x word (covers 011/110/111 loads as LW
  // and 011 stores as SW). funct3[2] selects zero extension on loads only.
  always_comb begin
    sz_byte   = (funct3_q[1:0] == 2'b00);
    sz_half   = (funct3_q[1:0] == 2'b01);
    shamt     = sz_byte ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
    lane_mask = sz_byte ? (32'h0000_00FF << shamt) : (32'h0000_FFFF << shamt);
    rd_shift  = mem_read_data >> shamt;
    merged    = (mem_read_data & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    if (sz_byte)
      load_ext = funct3_q[2] ? {24'h0, rd_shift[7:0]}
                             : {{24{rd_shift[7]}}, rd_shift[7:0]};
    else if (sz_half)
      load_ext = funct3_q[2] ? {16'h0, rd_shift[15:0]}
                             : {{16{rd_shift[15]}}, rd_shift[15:0]};
    else
      load_ext = mem_read_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      funct3_q   <= 3'b000;
      is_store_q <= 1'b0;
      mis_q      <= 1'b0;
      merge_q    <= 32'h0;
      rdata_q    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q     <= bus.addr;
            wdata_q    <= bus.wdata;
            funct3_q   <= bus.funct3;
            is_store_q <= bus.is_store;
            mis_q      <= req_mis;
            if (req_mis) begin
              state <= RESP;
              if (!bus.is_store)
                rdata_q <= 32'h0;
            end else if (!bus.is_store)
              state <= LOAD;
            else if (bus.funct3[1])
              state <= WRITE;
            else
              state <= MERGE;
          end
        end
        LOAD: begin
          rdata_q <= load_ext;
          state   <= RESP;
        end
        MERGE: begin
          merge_q <= merged;
          state   <= WRITE;
        end
        WRITE: state <= RESP;
        RESP: begin
          state <= IDLE;
          if (LOAD_RESP_REG)
            rdata_q <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state == IDLE);
  assign bus.resp_valid   = (state == RESP);
  assign bus.rdata        = rdata_q;
  assign bus.misaligned   = mis_q & (state == RESP);
  assign mem_addr         = (state == IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
  assign mem_should_write = (state == WRITE) & is_store_q;
  assign mem_write_data   = (state != WRITE) ? 32'h0
                          : (funct3_q[1] ? wdata_q : merge_q);

endmodule
